// File: rtl/ahb_apb_bridge_lite_pkg.sv
// rtl/ahb_apb_bridge_lite_pkg.sv - shared types and constants for the AHB-Lite to APB bridge
//
// Purpose: bridge FSM state encoding, AHB transfer/size encodings and slot
//          address geometry shared by the bridge top and its slot decoder.
// Ports:   none (package).
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    DONE   = 3'd3,
    ERR1   = 3'd4,
    ERR2   = 3'd5
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // 4 KB slots: HADDR[15:12] selects the APB slave.
  localparam int SLOT_LSB = 12;
  localparam int SLOT_W   = 4;

  // Only NONSEQ and SEQ carry a real transfer.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_apb_bridge_lite_if.sv
// rtl/ahb_apb_bridge_lite_if.sv - AHB-Lite slave side and APB master side signal bundle
//
// Purpose: groups the AHB-Lite and APB bus signals of the bridge.
// Modports:
//   slave  - bridge view: AHB-Lite slave, APB master.
//   master - environment view: AHB master plus the APB slaves' responses.
// Signals: HSEL, HADDR[15:0], HTRANS[1:0], HWRITE, HSIZE[2:0], HWDATA[31:0],
//          HREADY, HREADYOUT, HRESP, HRDATA[31:0], PADDR[11:0],
//          PSEL[NUM_SLAVES-1:0], PENABLE, PWRITE, PWDATA[31:0],
//          PRDATA[32*NUM_SLAVES-1:0], PREADY[NUM_SLAVES-1:0],
//          PSLVERR[NUM_SLAVES-1:0].
interface ahb_apb_bridge_lite_if #(
  parameter int NUM_SLAVES = 8
);
  logic                      HSEL;
  logic [15:0]               HADDR;
  logic [1:0]                HTRANS;
  logic                      HWRITE;
  logic [2:0]                HSIZE;
  logic [31:0]               HWDATA;
  logic                      HREADY;
  logic                      HREADYOUT;
  logic                      HRESP;
  logic [31:0]               HRDATA;
  logic [11:0]               PADDR;
  logic [NUM_SLAVES-1:0]     PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [31:0]               PWDATA;
  logic [32*NUM_SLAVES-1:0]  PRDATA;
  logic [NUM_SLAVES-1:0]     PREADY;
  logic [NUM_SLAVES-1:0]     PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  PRDATA, PREADY, PSLVERR,
    output HREADYOUT, HRESP, HRDATA,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output PRDATA, PREADY, PSLVERR,
    input  HREADYOUT, HRESP, HRDATA,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

endinterface

// File: rtl/ahb_apb_bridge_lite_slot_decode.sv
// rtl/ahb_apb_bridge_lite_slot_decode.sv - combinational APB slot decoder and response mux
//
// Purpose: turns a slot index into a one-hot PSEL enable and selects that
//          slot's PRDATA/PREADY/PSLVERR. Slots at or above NUM_SLAVES are
//          flagged illegal and select nothing.
// Ports:
//   i_slot      in  SLOT_W         slot index
//   i_prdata    in  32*NUM_SLAVES  per-slot read data
//   i_pready    in  NUM_SLAVES     per-slot ready
//   i_pslverr   in  NUM_SLAVES     per-slot error
//   o_psel_en   out NUM_SLAVES     one-hot select (all zero when illegal)
//   o_prdata    out 32             selected read data
//   o_pready    out 1              selected ready
//   o_pslverr   out 1              selected error
//   o_illegal   out 1              slot index out of range
module apb_slot_decode
  import ahb_apb_pkg::*;
#(
  parameter int NUM_SLAVES = 8
) (
  input  logic [SLOT_W-1:0]         i_slot,
  input  logic [32*NUM_SLAVES-1:0]  i_prdata,
  input  logic [NUM_SLAVES-1:0]     i_pready,
  input  logic [NUM_SLAVES-1:0]     i_pslverr,
  output logic [NUM_SLAVES-1:0]     o_psel_en,
  output logic [31:0]               o_prdata,
  output logic                      o_pready,
  output logic                      o_pslverr,
  output logic                      o_illegal
);

  always_comb begin
    o_psel_en = '0;
    o_prdata  = '0;
    o_pready  = 1'b0;
    o_pslverr = 1'b0;
    o_illegal = (32'(i_slot) >= 32'(NUM_SLAVES));
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (i_slot == SLOT_W'(i)) begin
        o_psel_en[i] = 1'b1;
        o_prdata     = i_prdata[32*i +: 32];
        o_pready     = i_pready[i];
        o_pslverr    = i_pslverr[i];
      end
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_lite.sv
// rtl/ahb_apb_bridge_lite.sv - single-clock AHB-Lite slave to APB master bridge
//
// Purpose: converts each accepted AHB-Lite word transfer into one APB
//          setup/access sequence on a 4 KB slot, returns read data and
//          two-cycle ERROR responses, and aborts accesses whose slave holds
//          PREADY low for TIMEOUT cycles.
// Parameters: NUM_SLAVES (APB slots), TIMEOUT (1..1023 ACCESS wait cycles).
// Ports:
//   PCLK     in  clock (AHB side shares it)
//   PRESETN  in  asynchronous active-low reset
//   bus      ahb_apb_bridge_lite_if.slave - AHB-Lite slave and APB master signals
module ahb_apb_bridge_lite
  import ahb_apb_pkg::*;
#(
  parameter int NUM_SLAVES = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                        PCLK,
  input  logic                        PRESETN,
  ahb_apb_bridge_lite_if.slave        bus
);

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  state_t                  r_state;
  logic [SLOT_W-1:0]       r_slot;
  logic [9:0]              r_tcnt;
  logic                    r_hreadyout;
  logic                    r_hresp;
  logic [31:0]             r_hrdata;
  logic [NUM_SLAVES-1:0]   r_psel;
  logic                    r_penable;
  logic [11:0]             r_paddr;
  logic                    r_pwrite;

  logic                    w_idle_like;
  logic                    w_accept;
  logic                    w_bad;
  logic [SLOT_W-1:0]       w_haddr_slot;
  logic [SLOT_W-1:0]       w_dec_slot;
  logic [NUM_SLAVES-1:0]   w_psel_en;
  logic [31:0]             w_prdata;
  logic                    w_pready;
  logic                    w_pslverr;
  logic                    w_illegal;
  logic                    w_unused;

  assign w_unused     = &{1'b0, bus.HADDR[1:0]};
  assign w_haddr_slot = bus.HADDR[SLOT_LSB +: SLOT_W];

  // HREADYOUT is high only in these states, so only they can take a new address.
  assign w_idle_like = (r_state == IDLE) || (r_state == DONE) || (r_state == ERR2);
  assign w_accept    = w_idle_like && bus.HSEL && htrans_active(bus.HTRANS) && bus.HREADY;

  // One decoder serves both jobs: while able to accept it decodes the incoming
  // address; during SETUP/ACCESS it muxes the latched slot's responses.
  assign w_dec_slot = w_idle_like ? w_haddr_slot : r_slot;

  apb_slot_decode #(
    .NUM_SLAVES (NUM_SLAVES)
  ) u_slot_decode (
    .i_slot     (w_dec_slot),
    .i_prdata   (bus.PRDATA),
    .i_pready   (bus.PREADY),
    .i_pslverr  (bus.PSLVERR),
    .o_psel_en  (w_psel_en),
    .o_prdata   (w_prdata),
    .o_pready   (w_pready),
    .o_pslverr  (w_pslverr),
    .o_illegal  (w_illegal)
  );

  assign w_bad = w_illegal || (bus.HSIZE != HSIZE_WORD);

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state     <= IDLE;
      r_slot      <= '0;
      r_tcnt      <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_hrdata    <= '0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE, ERR2: begin
          r_penable <= 1'b0;
          if (w_accept) begin
            r_slot <= w_haddr_slot;
            if (w_bad) begin
              r_state     <= ERR1;
              r_psel      <= '0;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
            end else begin
              r_state     <= SETUP;
              r_psel      <= w_psel_en;
              r_paddr     <= {bus.HADDR[11:2], 2'b00};
              r_pwrite    <= bus.HWRITE;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b0;
            end
          end else begin
            r_state     <= IDLE;
            r_psel      <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end

        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
          r_tcnt    <= '0;
        end

        ACCESS: begin
          if (w_pready) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            if (w_pslverr) begin
              r_state <= ERR1;
              r_hresp <= 1'b1;
            end else begin
              r_state     <= DONE;
              r_hreadyout <= 1'b1;
              if (!r_pwrite) begin
                r_hrdata <= w_prdata;
              end
            end
          end else if (r_tcnt == TMO_LAST) begin
            // TIMEOUT consecutive low-PREADY cycles: abandon the APB access.
            r_state   <= ERR1;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_hresp   <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 10'd1;
          end
        end

        ERR1: begin
          r_state     <= ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end

        default: begin
          r_state     <= IDLE;
          r_psel      <= '0;
          r_penable   <= 1'b0;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.HREADYOUT = r_hreadyout;
  assign bus.HRESP     = r_hresp;
  assign bus.HRDATA    = r_hrdata;
  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PADDR     = r_paddr;
  assign bus.PWRITE    = r_pwrite;
  // The master holds HWDATA while HREADYOUT is low, so a pass-through is stable.
  assign bus.PWDATA    = ((r_state == SETUP) || (r_state == ACCESS)) ? bus.HWDATA : 32'd0;

endmodule

// File: tb/tb_ahb_apb_bridge_lite.sv
// tb/tb_ahb_apb_bridge_lite.sv - directed self-checking bench for ahb_apb_bridge_lite
module tb_ahb_apb_bridge_lite;

  logic pclk;
  logic presetn;
  int   checks = 0;
  int   errors = 0;

  ahb_apb_bridge_lite_if #(.NUM_SLAVES(8)) bus ();

  ahb_apb_bridge_lite #(
    .NUM_SLAVES (8),
    .TIMEOUT    (4)
  ) dut (
    .PCLK    (pclk),
    .PRESETN (presetn),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic addr_phase(input logic [15:0] addr, input logic wr, input logic [2:0] size);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = addr;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
  endtask

  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
  endtask

  task automatic test_reset();
    presetn     = 1'b0;
    bus_idle();
    bus.HADDR   = '0;
    bus.HWRITE  = 1'b0;
    bus.HSIZE   = 3'b010;
    bus.HWDATA  = '0;
    bus.HREADY  = 1'b1;
    bus.PRDATA  = '0;
    bus.PREADY  = '1;
    bus.PSLVERR = '0;
    tick();
    checks++; if (bus.HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_hreadyout got %b want 1", bus.HREADYOUT); end
    checks++; if (bus.HRESP !== 1'b0) begin errors++; $display("FAIL reset_hresp got %b want 0", bus.HRESP); end
    checks++; if (bus.HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata got %h want 0", bus.HRDATA); end
    checks++; if (bus.PSEL !== 8'h00) begin errors++; $display("FAIL reset_psel got %h want 00", bus.PSEL); end
    checks++; if (bus.PENABLE !== 1'b0) begin errors++; $display("FAIL reset_penable got %b want 0", bus.PENABLE); end
    checks++; if (bus.PADDR !== 12'h0) begin errors++; $display("FAIL reset_paddr got %h want 0", bus.PADDR); end
    checks++; if (bus.PWRITE !== 1'b0) begin errors++; $display("FAIL reset_pwrite got %b want 0", bus.PWRITE); end
    checks++; if (bus.PWDATA !== 32'h0) begin errors++; $display("FAIL reset_pwdata got %h want 0", bus.PWDATA); end
    presetn = 1'b1;
    tick();
  endtask

  task automatic test_write();
    addr_phase(16'h1000, 1'b1, 3'b010);
    tick();
    bus_idle();
    bus.HWDATA = 32'h0000_0055;
    #1;
    checks++; if (bus.PSEL !== 8'b0000_0010) begin errors++; $display("FAIL wr_setup_psel got %b want 00000010", bus.PSEL); end
    checks++; if (bus.PENABLE !== 1'b0) begin errors++; $display("FAIL wr_setup_penable got %b want 0", bus.PENABLE); end
    checks++; if (bus.PWDATA !== 32'h55) begin errors++; $display("FAIL wr_setup_pwdata got %h want 55", bus.PWDATA); end
    checks++; if (bus.HREADYOUT !== 1'b0) begin errors++; $display("FAIL wr_setup_hreadyout got %b want 0", bus.HREADYOUT); end
    checks++; if (bus.PWRITE !== 1'b1 || bus.PADDR !== 12'h000) begin errors++; $display("FAIL wr_setup_addr got %b/%h want 1/000", bus.PWRITE, bus.PADDR); end
    tick();
    checks++; if (bus.PSEL !== 8'b0000_0010) begin errors++; $display("FAIL wr_access_psel got %b want 00000010", bus.PSEL); end
    checks++; if (bus.PENABLE !== 1'b1) begin errors++; $display("FAIL wr_access_penable got %b want 1", bus.PENABLE); end
    checks++; if (bus.PWDATA !== 32'h55) begin errors++; $display("FAIL wr_access_pwdata got %h want 55", bus.PWDATA); end
    tick();
    checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin errors++; $display("FAIL wr_done_resp got %b/%b want 1/0", bus.HREADYOUT, bus.HRESP); end
    checks++; if (bus.PSEL !== 8'h00 || bus.PENABLE !== 1'b0) begin errors++; $display("FAIL wr_done_apb got %h/%b want 00/0", bus.PSEL, bus.PENABLE); end
    checks++; if (bus.PWDATA !== 32'h0) begin errors++; $display("FAIL wr_done_pwdata got %h want 0", bus.PWDATA); end
    tick();
  endtask

  task automatic test_wait_read();
    int waits = 0;
    int acc   = 0;
    bit done  = 0;
    bus.PRDATA[32*1 +: 32] = 32'h0000_0002;
    bus.PREADY[1] = 1'b0;
    addr_phase(16'h1004, 1'b0, 3'b010);
    tick();
    bus_idle();
    checks++; if (bus.PADDR !== 12'h004 || bus.PWRITE !== 1'b0) begin errors++; $display("FAIL rd_setup_addr got %h/%b want 004/0", bus.PADDR, bus.PWRITE); end
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.HREADYOUT) begin
        done = 1;
      end else begin
        waits++;
        if (bus.PENABLE) begin
          acc++;
          bus.PREADY[1] = (acc == 4);
        end
        tick();
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rd_wait_done got %b want 1", done); end
    checks++; if (acc != 4) begin errors++; $display("FAIL rd_access_cycles got %0d want 4", acc); end
    checks++; if (waits != 5) begin errors++; $display("FAIL rd_wait_states got %0d want 5", waits); end
    checks++; if (bus.HRDATA !== 32'h2) begin errors++; $display("FAIL rd_hrdata got %h want 00000002", bus.HRDATA); end
    checks++; if (bus.HRESP !== 1'b0) begin errors++; $display("FAIL rd_hresp got %b want 0", bus.HRESP); end
    bus.PREADY = '1;
    tick();
  endtask

  task automatic test_slverr();
    bus.PRDATA[32*2 +: 32] = 32'hDEAD_BEEF;
    bus.PSLVERR[2] = 1'b1;
    addr_phase(16'h2000, 1'b0, 3'b010);
    tick();
    bus_idle();
    checks++; if (bus.PSEL !== 8'b0000_0100) begin errors++; $display("FAIL err_setup_psel got %b want 00000100", bus.PSEL); end
    tick();
    tick();
    checks++; if (bus.HREADYOUT !== 1'b0 || bus.HRESP !== 1'b1) begin errors++; $display("FAIL err_first got %b/%b want 0/1", bus.HREADYOUT, bus.HRESP); end
    tick();
    checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b1) begin errors++; $display("FAIL err_second got %b/%b want 1/1", bus.HREADYOUT, bus.HRESP); end
    tick();
    checks++; if (bus.HRESP !== 1'b0) begin errors++; $display("FAIL err_end_hresp got %b want 0", bus.HRESP); end
    checks++; if (bus.HRDATA !== 32'h2) begin errors++; $display("FAIL err_hrdata_kept got %h want 00000002", bus.HRDATA); end
    bus.PSLVERR = '0;
  endtask

  task automatic test_illegal_slot();
    logic [7:0] psel_seen = '0;
    addr_phase(16'h9000, 1'b1, 3'b010);
    tick();
    bus_idle();
    psel_seen |= bus.PSEL;
    checks++; if (bus.HREADYOUT !== 1'b0 || bus.HRESP !== 1'b1) begin errors++; $display("FAIL ill_first got %b/%b want 0/1", bus.HREADYOUT, bus.HRESP); end
    tick();
    psel_seen |= bus.PSEL;
    checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b1) begin errors++; $display("FAIL ill_second got %b/%b want 1/1", bus.HREADYOUT, bus.HRESP); end
    tick();
    psel_seen |= bus.PSEL;
    checks++; if (bus.HRESP !== 1'b0 || bus.HREADYOUT !== 1'b1) begin errors++; $display("FAIL ill_end got %b/%b want 1/0", bus.HREADYOUT, bus.HRESP); end
    checks++; if (psel_seen !== 8'h00) begin errors++; $display("FAIL ill_psel got %h want 00", psel_seen); end
  endtask

  task automatic test_timeout();
    int  pen  = 0;
    bit  left = 0;
    bus.PREADY[3] = 1'b0;
    addr_phase(16'h3000, 1'b0, 3'b010);
    tick();
    bus_idle();
    for (int i = 0; i < 20 && !left; i++) begin
      tick();
      if (bus.PENABLE) pen++;
      else left = 1;
    end
    checks++; if (pen != 4) begin errors++; $display("FAIL tmo_penable_cycles got %0d want 4", pen); end
    checks++; if (bus.PSEL !== 8'h00) begin errors++; $display("FAIL tmo_psel got %h want 00", bus.PSEL); end
    checks++; if (bus.HREADYOUT !== 1'b0 || bus.HRESP !== 1'b1) begin errors++; $display("FAIL tmo_err1 got %b/%b want 0/1", bus.HREADYOUT, bus.HRESP); end
    tick();
    checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b1) begin errors++; $display("FAIL tmo_err2 got %b/%b want 1/1", bus.HREADYOUT, bus.HRESP); end
    bus.PREADY = '1;
    tick();
    addr_phase(16'h0000, 1'b1, 3'b010);
    tick();
    bus_idle();
    bus.HWDATA = 32'h0000_00A5;
    checks++; if (bus.PSEL !== 8'h01) begin errors++; $display("FAIL tmo_next_psel got %h want 01", bus.PSEL); end
    tick();
    tick();
    checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin errors++; $display("FAIL tmo_next_done got %b/%b want 1/0", bus.HREADYOUT, bus.HRESP); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.PRDATA[32*0 +: 32] = 32'h0BAD_F00D;
    addr_phase(16'h0008, 1'b1, 3'b010);
    tick();
    bus.HWDATA = 32'h0000_1234;
    addr_phase(16'h000C, 1'b0, 3'b010);
    checks++; if (bus.PWRITE !== 1'b1 || bus.PADDR !== 12'h008) begin errors++; $display("FAIL b2b_first_addr got %b/%h want 1/008", bus.PWRITE, bus.PADDR); end
    tick();
    checks++; if (bus.PWDATA !== 32'h1234) begin errors++; $display("FAIL b2b_pwdata got %h want 00001234", bus.PWDATA); end
    tick();
    checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin errors++; $display("FAIL b2b_first_done got %b/%b want 1/0", bus.HREADYOUT, bus.HRESP); end
    tick();
    bus_idle();
    checks++; if (bus.PSEL !== 8'h01 || bus.PENABLE !== 1'b0) begin errors++; $display("FAIL b2b_second_setup got %h/%b want 01/0", bus.PSEL, bus.PENABLE); end
    checks++; if (bus.PWRITE !== 1'b0 || bus.PADDR !== 12'h00C) begin errors++; $display("FAIL b2b_second_addr got %b/%h want 0/00c", bus.PWRITE, bus.PADDR); end
    tick();
    tick();
    checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRDATA !== 32'h0BAD_F00D) begin errors++; $display("FAIL b2b_read got %b/%h want 1/0badf00d", bus.HREADYOUT, bus.HRDATA); end
    bus.PREADY[0] = 1'b0;
    addr_phase(16'h0010, 1'b0, 3'b010);
    tick();
    bus_idle();
    tick();
    checks++; if (bus.PENABLE !== 1'b1) begin errors++; $display("FAIL b2b_third_access got %b want 1", bus.PENABLE); end
    presetn = 1'b0;
    #1;
    checks++; if (bus.PSEL !== 8'h00 || bus.PENABLE !== 1'b0) begin errors++; $display("FAIL rst_mid_apb got %h/%b want 00/0", bus.PSEL, bus.PENABLE); end
    checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRDATA !== 32'h0) begin errors++; $display("FAIL rst_mid_ahb got %b/%h want 1/00000000", bus.HREADYOUT, bus.HRDATA); end
    #2;
    presetn = 1'b1;
    bus.PREADY = '1;
    tick();
    checks++; if (bus.PSEL !== 8'h00 || bus.HREADYOUT !== 1'b1) begin errors++; $display("FAIL rst_after got %h/%b want 00/1", bus.PSEL, bus.HREADYOUT); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wait_read();
    test_slverr();
    test_illegal_slot();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
